// File: rtl/spi_master.sv
// SPI mode-0 master: one DATA_W-bit full-duplex frame per accepted start.
// ss is active-high and all SPI pins are registered.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              ss_q, ss_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

  assign tick = (div_q == DIV_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      ss_q      <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          tx_sr_d = tx_data;
          rx_sr_d = '0;
          bit_d   = '0;
          ss_d    = 1'b1;
          mosi_d  = tx_data[DATA_W-1];
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // the edge closing the lead time is the first sclk rise
        if (tick) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          bit_d   = bit_q + 1'b1;
          state_d = XFER;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      XFER: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            bit_d = bit_q + 1'b1;
          end else begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
            if (bit_q == BIT_MAX) begin
              state_d = HOLD;
            end else begin
              tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
              mosi_d  = tx_sr_q[DATA_W-2];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          div_d     = '0;
          ss_d      = 1'b0;
          mosi_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          state_d   = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign ss      = ss_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule
